// File: rtl/prog_loader.sv
// Program image loader: takes a length word, N program words and a checksum word,
// writes the program words into RAM and reports done or err.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bus_req,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              wr_en_out,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Wide enough to hold BASE_ADDR + N and 2^ADDR_W without wrapping.
    localparam int unsigned EXT_W = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 2;
    localparam logic [EXT_W-1:0] BASE_EXT = EXT_W'(BASE_ADDR);
    localparam logic [EXT_W-1:0] SPACE    = EXT_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] remain_reg, remain_next;
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
    logic              in_ready_reg, in_ready_next;
    logic              bus_req_reg, bus_req_next;
    logic [ADDR_W-1:0] addr_out_reg, addr_out_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic              wr_en_reg, wr_en_next;
    logic              cpu_hold_reg, cpu_hold_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              accept;
    logic [EXT_W-1:0]  len_ext;

    assign accept  = in_valid && in_ready_reg;
    assign len_ext = EXT_W'(in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            remain_reg   <= '0;
            sum_reg      <= '0;
            addr_cnt_reg <= '0;
            in_ready_reg <= 1'b0;
            bus_req_reg  <= 1'b0;
            addr_out_reg <= '0;
            data_out_reg <= '0;
            wr_en_reg    <= 1'b0;
            cpu_hold_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            remain_reg   <= remain_next;
            sum_reg      <= sum_next;
            addr_cnt_reg <= addr_cnt_next;
            in_ready_reg <= in_ready_next;
            bus_req_reg  <= bus_req_next;
            addr_out_reg <= addr_out_next;
            data_out_reg <= data_out_next;
            wr_en_reg    <= wr_en_next;
            cpu_hold_reg <= cpu_hold_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        remain_next   = remain_reg;
        sum_next      = sum_reg;
        addr_cnt_next = addr_cnt_reg;
        in_ready_next = in_ready_reg;
        bus_req_next  = bus_req_reg;
        addr_out_next = addr_out_reg;
        data_out_next = data_out_reg;
        wr_en_next    = 1'b0;
        cpu_hold_next = cpu_hold_reg;
        done_next     = done_reg;
        err_next      = err_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next    = S_LEN;
                    in_ready_next = 1'b1;
                    bus_req_next  = 1'b1;
                    cpu_hold_next = 1'b1;
                    done_next     = 1'b0;
                    err_next      = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    remain_next   = in_data;
                    sum_next      = '0;
                    addr_cnt_next = ADDR_W'(BASE_ADDR);
                    if (BASE_EXT + len_ext > SPACE) begin
                        state_next    = S_ERR;
                        err_next      = 1'b1;
                        bus_req_next  = 1'b0;
                        in_ready_next = 1'b0;
                    end else if (in_data == '0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_next    = 1'b1;
                    addr_out_next = addr_cnt_reg;
                    data_out_next = in_data;
                    addr_cnt_next = addr_cnt_reg + ADDR_W'(1);
                    sum_next      = sum_reg + in_data;
                    remain_next   = remain_reg - DATA_W'(1);
                    if (remain_reg == DATA_W'(1)) begin
                        state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    in_ready_next = 1'b0;
                    bus_req_next  = 1'b0;
                    if (in_data == sum_reg) begin
                        state_next    = S_DONE;
                        done_next     = 1'b1;
                        cpu_hold_next = 1'b0;
                    end else begin
                        state_next = S_ERR;
                        err_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_reg;
    assign bus_req   = bus_req_reg;
    assign addr_out  = addr_out_reg;
    assign data_out  = data_out_reg;
    assign wr_en_out = wr_en_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a table of directed images, hand-written reset/restart
// sequences and randomized images, all checked against an image-level model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel = 1'b0;

    always #5 clk = ~clk;

    logic       a_in_ready, a_bus_req, a_wr_en, a_cpu_hold, a_done, a_err;
    logic [7:0] a_addr, a_data;
    logic       b_in_ready, b_bus_req, b_wr_en, b_cpu_hold, b_done, b_err;
    logic [7:0] b_addr, b_data;

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .bus_req(a_bus_req), .addr_out(a_addr), .data_out(a_data),
        .wr_en_out(a_wr_en), .cpu_hold(a_cpu_hold), .done(a_done), .err(a_err)
    );

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(32'hF0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .bus_req(b_bus_req), .addr_out(b_addr), .data_out(b_data),
        .wr_en_out(b_wr_en), .cpu_hold(b_cpu_hold), .done(b_done), .err(b_err)
    );

    logic       o_in_ready, o_bus_req, o_wr_en, o_cpu_hold, o_done, o_err;
    logic [7:0] o_addr, o_data;
    assign o_in_ready = sel ? b_in_ready : a_in_ready;
    assign o_bus_req  = sel ? b_bus_req  : a_bus_req;
    assign o_wr_en    = sel ? b_wr_en    : a_wr_en;
    assign o_cpu_hold = sel ? b_cpu_hold : a_cpu_hold;
    assign o_done     = sel ? b_done     : a_done;
    assign o_err      = sel ? b_err      : a_err;
    assign o_addr     = sel ? b_addr     : a_addr;
    assign o_data     = sel ? b_data     : a_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] img [0:63];

    typedef struct {
        logic       sel;
        int         mode;      // 0 valid always, 1 toggling, 2 random
        int         n;
        logic [7:0] w0;
        logic [7:0] dw;
        logic [7:0] csum;
        logic       exp_done;
        logic       exp_err;
        int         exp_writes;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_image(input int n, input logic [7:0] w0, input logic [7:0] dw,
                              input logic [7:0] csum);
        img[0] = 8'(n);
        for (int i = 0; i < n; i++) img[i+1] = 8'(int'(w0) + i * int'(dw));
        img[n+1] = csum;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(o_in_ready), 0);
        chk("rst_bus_req",  32'(o_bus_req), 0);
        chk("rst_wr_en",    32'(o_wr_en), 0);
        chk("rst_cpu_hold", 32'(o_cpu_hold), 0);
        chk("rst_done",     32'(o_done), 0);
        chk("rst_err",      32'(o_err), 0);
        chk("rst_addr",     32'(o_addr), 0);
        chk("rst_data",     32'(o_data), 0);
        rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(o_in_ready), 0);
    endtask

    // Streams img[] into the selected loader and checks each cycle against what the
    // image implies: writes land at base+i one cycle after the i-th program word.
    task automatic run_image(input int mode, output int writes,
                             output logic fin_done, output logic fin_err);
        int n, base, nwords, k, cyc;
        logic ovf, exp_ok, acc, exp_wr;
        logic [7:0] sum;
        n = int'(img[0]);
        base = sel ? 32'hF0 : 0;
        ovf = (base + n) > 256;
        sum = 8'h00;
        if (!ovf) for (int i = 1; i <= n; i++) sum = sum + img[i];
        exp_ok = !ovf && (sum == img[n+1]);
        nwords = ovf ? 1 : n + 2;
        writes = 0;

        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
        chk("start_in_ready", 32'(o_in_ready), 1);
        chk("start_bus_req",  32'(o_bus_req), 1);
        chk("start_cpu_hold", 32'(o_cpu_hold), 1);
        chk("start_done",     32'(o_done), 0);
        chk("start_err",      32'(o_err), 0);

        k = 0; cyc = 0;
        while (k < nwords && cyc < 2000) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = ((cyc % 2) == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? img[k] : 8'($urandom);
            acc = in_valid && o_in_ready;
            step();
            exp_wr = acc && (k >= 1) && (k <= n);
            chk("wr_en", 32'(o_wr_en), 32'(exp_wr));
            if (o_wr_en) writes++;
            if (exp_wr) begin
                chk("wr_addr", 32'(o_addr), 32'((base + k - 1) % 256));
                chk("wr_data", 32'(o_data), 32'(img[k]));
            end
            if (acc) k++;
            if (k < nwords) begin
                chk("load_in_ready", 32'(o_in_ready), 1);
                chk("load_bus_req",  32'(o_bus_req), 1);
                chk("load_done_err", 32'({o_done, o_err}), 0);
            end
            cyc++;
        end
        if (k < nwords) chk("accept_timeout", 32'(k), 32'(nwords));
        in_valid = 1'b0;

        chk("verdict_done",     32'(o_done), 32'(exp_ok));
        chk("verdict_err",      32'(o_err), 32'(!exp_ok));
        chk("verdict_cpu_hold", 32'(o_cpu_hold), 32'(!exp_ok));
        chk("verdict_bus_req",  32'(o_bus_req), 0);
        chk("verdict_in_ready", 32'(o_in_ready), 0);
        fin_done = o_done;
        fin_err  = o_err;

        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            step();
            chk("after_wr_en",    32'(o_wr_en), 0);
            chk("after_in_ready", 32'(o_in_ready), 0);
            chk("after_hold",     32'({o_done, o_err}), 32'({exp_ok, !exp_ok}));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        logic d, e;
        logic prev_sel;

        tbl[0] = '{1'b0, 0, 4,     8'h11, 8'h11, 8'hAA, 1'b1, 1'b0, 4};
        tbl[1] = '{1'b0, 0, 4,     8'h11, 8'h11, 8'hAB, 1'b0, 1'b1, 4};
        tbl[2] = '{1'b0, 0, 0,     8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0};
        tbl[3] = '{1'b1, 0, 32,    8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 0};
        tbl[4] = '{1'b0, 1, 3,     8'h05, 8'h10, 8'h3F, 1'b1, 1'b0, 3};
        tbl[5] = '{1'b1, 0, 16,    8'h01, 8'h01, 8'h88, 1'b1, 1'b0, 16};
        tbl[6] = '{1'b1, 0, 17,    8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0};
        tbl[7] = '{1'b0, 2, 6,     8'hF0, 8'h07, 8'h09, 1'b1, 1'b0, 6};
        tbl[8] = '{1'b0, 0, 1,     8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, 1};

        sel = 1'b0;
        do_reset();
        prev_sel = 1'b0;

        // A start after done/err is taken without reset (entries 1 and 2 rely on it).
        for (int t = 0; t < 9; t++) begin
            sel = tbl[t].sel;
            if (sel || (prev_sel != sel)) do_reset();
            prev_sel = sel;
            fill_image(tbl[t].n, tbl[t].w0, tbl[t].dw, tbl[t].csum);
            run_image(tbl[t].mode, w, d, e);
            chk("tbl_done",   32'(d), 32'(tbl[t].exp_done));
            chk("tbl_err",    32'(e), 32'(tbl[t].exp_err));
            chk("tbl_writes", 32'(w), 32'(tbl[t].exp_writes));
            $display("table %0d: base=%0s n=%0d csum=%02h done=%0d err=%0d writes=%0d",
                     t, sel ? "F0" : "00", tbl[t].n, tbl[t].csum, d, e, w);
        end

        // Reset in the middle of a load, then a clean reload.
        sel = 1'b0;
        do_reset();
        fill_image(4, 8'h11, 8'h11, 8'hAA);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = img[k];
            step();
            chk("rml_wr_en", 32'(o_wr_en), 32'(k >= 1));
            if (k >= 1) chk("rml_addr", 32'(o_addr), 32'(k - 1));
        end
        rst = 1'b1; in_data = img[3];
        step();
        chk("rml_in_ready", 32'(o_in_ready), 0);
        chk("rml_bus_req",  32'(o_bus_req), 0);
        chk("rml_wr_en0",   32'(o_wr_en), 0);
        chk("rml_cpu_hold", 32'(o_cpu_hold), 0);
        chk("rml_done_err", 32'({o_done, o_err}), 0);
        chk("rml_addr_data", 32'({o_addr, o_data}), 0);
        rst = 1'b0;
        step();
        chk("rml_idle_wr_en", 32'(o_wr_en), 0);
        chk("rml_idle_ready", 32'(o_in_ready), 0);
        in_valid = 1'b0;
        run_image(0, w, d, e);
        chk("rml_reload_done", 32'(d), 1);
        chk("rml_reload_writes", 32'(w), 4);
        $display("reset mid-load then reload: done=%0d err=%0d writes=%0d", d, e, w);

        // Randomized images on both base addresses.
        for (int r = 0; r < 30; r++) begin
            int n;
            logic [7:0] s;
            sel = 1'($urandom_range(0, 1));
            do_reset();
            n = sel ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 12));
            img[0] = 8'(n);
            s = 8'h00;
            for (int i = 1; i <= n; i++) begin
                img[i] = 8'($urandom);
                s = s + img[i];
            end
            img[n+1] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : s;
            run_image(int'($urandom_range(0, 2)), w, d, e);
            $display("random %0d: base=%0s n=%0d csum=%02h done=%0d err=%0d writes=%0d",
                     r, sel ? "F0" : "00", n, img[n+1], d, e, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Streams a program image from an external word source into RAM over the shared address/data bus before the CPU runs.
- Sits directly upstream of the RAM. While loading it owns the bus and holds the CPU off the bus.
- Image format, in order: one length word N, then N program words, then one checksum word.
- Reports completion with `done` or integrity/overflow failure with `err`.

Parameters:
- ADDR_W, 8, address bus width. Top level ties it to `ADDR_SIZE`.
- DATA_W, 8, data word width. Top level ties it to `WORD_SIZE`.
- BASE_ADDR, 0, RAM address of the first program word.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load.
- in_valid  input  1  source presents a word on in_data.
- in_data  input  DATA_W  image word.
- in_ready  output  1  loader accepts a word this cycle.
- bus_req  output  1  loader owns addr/data/wr_en; top level muxes the bus on this.
- addr_out  output  ADDR_W  RAM write address.
- data_out  output  DATA_W  RAM write data.
- wr_en_out  output  1  RAM write strobe, one cycle per word.
- cpu_hold  output  1  holds the CPU in reset; ORed with rst at top level.
- done  output  1  load completed and checksum matched.
- err  output  1  checksum mismatch or length overflow.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; in_ready, bus_req, wr_en_out, cpu_hold, done, err = 0; addr_out, data_out = 0; internal count and sum = 0.
- A word is accepted in a cycle where in_valid && in_ready.
- in_ready = 1 only in states LEN, LOAD and CSUM.
- States:
  - IDLE: on start, go to LEN. Set cpu_hold=1 and bus_req=1 from the next cycle.
  - LEN: on accept, latch N, clear sum, set addr counter = BASE_ADDR.
    - If BASE_ADDR + N > 2^ADDR_W, go to ERR.
    - Else if N == 0, go to CSUM.
    - Else go to LOAD.
  - LOAD: each accepted word produces wr_en_out=1 on the following cycle, with addr_out = current counter and data_out = word.
    - The counter then increments; sum += word mod 2^DATA_W.
    - Back-to-back accepts give back-to-back write cycles.
    - After the Nth accept, go to CSUM.
  - CSUM: on accept, compare the word to sum.
    - Equal: go to DONE.
    - Not equal: go to ERR.
  - DONE: done=1, cpu_hold=0, bus_req=0, in_ready=0.
  - ERR: err=1, cpu_hold=1 (CPU stays held), bus_req=0, in_ready=0.
  - DONE and ERR hold until the next start, which clears done/err and goes to LEN.
- start is ignored in LEN, LOAD and CSUM.
- in_valid low stalls indefinitely. There is no timeout; no writes occur while stalled.
- wr_en_out is never asserted outside the cycle after a LOAD accept.
- bus_req stays 1 through the cycle carrying the last wr_en_out. It drops when DONE or ERR is entered.
- Latency: 1 cycle from accept to RAM write. Checksum verdict appears 1 cycle after the checksum word is accepted.
- Reset mid-load: all state returns to IDLE at the next edge and any pending write is dropped. The RAM contents already written are not restored.
- Address wrap cannot occur, because overflow is rejected at LEN.
- The checksum covers program words only, not the length word.

Test Plan:
- Normal load: start; stream N=4, words 0x11,0x22,0x33,0x44, then checksum 0xAA, with in_valid held high.
  - Writes at addr 0..3 on 4 consecutive cycles, data matches.
  - done=1 one cycle after the checksum accept; cpu_hold=0; bus_req=0.
- Bad checksum: same image with checksum 0xAB.
  - The 4 writes still occur.
  - err=1, done=0, cpu_hold stays 1.
  - A new start clears err.
- Zero length: N=0 then checksum 0x00.
  - No wr_en_out pulses; done=1.
- Overflow: BASE_ADDR=0xF0, N=0x20.
  - err=1 right after the length word; no writes; in_ready=0.
- Stalls: toggle in_valid 1/0 during LOAD with N=3.
  - Exactly 3 writes at consecutive addresses, only after accepts.
  - in_ready stays 1 while in_valid is low.
- Reset mid-load: assert rst after the 2nd program word.
  - The next cycle has IDLE, all outputs 0, and no further writes.
  - A fresh start reloads cleanly and reaches done.
